// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
//
// Purpose:
//   Time-shares one WIDTH-bit equality comparator among four requesters.
//   A round-robin arbiter picks one requester from IDLE. The winner's operands
//   are captured in LOAD and compared in EVAL. The result is presented for a
//   single cycle in RESP together with a DONE pulse. The grant is held from
//   the arbitration edge until the RESP cycle ends, and one IDLE cycle always
//   separates two operations.
//
// Ports:
//   clk        in   1          single clock, rising edge
//   reset_n    in   1          asynchronous active-low reset
//   req        in   4          per-requester request, bit i = requester i
//   a_in       in   4*WIDTH    packed operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in       in   4*WIDTH    packed operand B, same packing as a_in
//   gnt        out  4          one-hot grant, zero when no grant is active
//   gnt_id     out  2          index of the granted requester (valid with gnt)
//   done       out  1          one-cycle completion pulse (RESP cycle)
//   cmp        out  1          1 = operands equal; forced to 0 outside done
//   match_cnt  out  16         only with CMP_ARBITER_STATS_EN: saturating count
//                              of RESP cycles that reported a match
//
// Configuration macro:
//   CMP_ARBITER_STATS_EN  - adds the match_cnt output and its counter.
//
// States:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no operation; arbitrate on any non-zero req
//   ST_LOAD  | grant active; capture winner's A/B slices
//   ST_EVAL  | compare registered operands into result register
//   ST_RESP  | done=1, cmp=result; grant released on the next edge
// -----------------------------------------------------------------------------
module cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic [1:0]           gnt_id,
  output logic                 done,
  output logic                 cmp
`ifdef CMP_ARBITER_STATS_EN
  ,
  output logic [15:0]          match_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EVAL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               res_q, res_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               eq;

  // Round-robin search: start one past the last winner and wrap modulo 4.
  // Offset 4 wraps back onto the pointer itself, so the last winner is
  // considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Operand slice selected by the registered grant index.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_id_q == i[1:0]) begin
        sel_a = a_in[i*WIDTH +: WIDTH];
        sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // The single shared comparator works only on the registered operands.
  assign eq = &(opa_q ~^ opb_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_LOAD;
          gnt_d    = 4'b0001 << win_idx;
          gnt_id_d = win_idx;
          ptr_d    = win_idx;
        end
      end
      ST_LOAD: begin
        opa_d   = sel_a;
        opb_d   = sel_b;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        res_d   = eq;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // req is ignored here; a held request is re-arbitrated from IDLE.
        state_d  = ST_IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
      end
    endcase
  end

  // The pointer resets to 3 so that the first search after reset begins at
  // requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      ptr_q    <= 2'd3;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign done   = (state_q == ST_RESP);
  assign cmp    = done & res_q;

`ifdef CMP_ARBITER_STATS_EN
  logic [15:0] match_cnt_q, match_cnt_d;

  always_comb begin
    match_cnt_d = match_cnt_q;
    if (done && res_q && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_d = match_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt_q <= 16'h0000;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match_cnt = match_cnt_q;
`endif

  // Grant is one-hot or idle, and its index always agrees with it.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt_q));
  a_gnt_id_match: assert property (@(posedge clk) disable iff (!reset_n)
    (gnt_q != 4'b0000) |-> (gnt_q == (4'b0001 << gnt_id_q)));

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits of the shared equality comparator.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 REQ  input  4  per-requester request, bit i = requester i.
REQ-005 A_IN  input  4*WIDTH  packed operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-006 B_IN  input  4*WIDTH  packed operand B, same packing as A_IN.
REQ-007 GNT  output  4  one-hot grant, all-zero when no grant is active.
REQ-008 GNT_ID  output  2  binary index of the granted requester, valid while GNT is non-zero.
REQ-009 DONE  output  1  one-cycle completion pulse for the granted requester.
REQ-010 CMP  output  1  compare result, 1 = A equals B bitwise, valid only in the DONE cycle.

Function
REQ-011 The block SHALL time-share one internal WIDTH-bit equality comparator (CMP = AND-reduction of XNOR of operands) among 4 requesters.
REQ-012 FSM states SHALL be IDLE, LOAD, EVAL and RESP, encoded in 2 bits.
REQ-013 IDLE: if REQ is non-zero at an edge, the arbiter SHALL select the winner, assert GNT/GNT_ID, and go to LOAD; otherwise it stays in IDLE.
REQ-014 LOAD: the winner's A/B slices SHALL be captured into internal registers, then go to EVAL.
REQ-015 EVAL: the comparator output on the registered operands SHALL be captured into a result register, then go to RESP.
REQ-016 RESP: DONE=1 and CMP=result for exactly one cycle, GNT still held; on the next edge GNT clears and the FSM returns to IDLE.
REQ-017 Latency SHALL be fixed: with REQ sampled at edge k, GNT is high after k, DONE is high in the cycle after edge k+2, and GNT is low after k+3.
REQ-018 Arbitration SHALL be round-robin: a 2-bit pointer holds the last winner, and the search starts at pointer+1 modulo 4.
REQ-019 The pointer SHALL update to the winner's index at the IDLE-to-LOAD transition.
REQ-020 Wrap-around: with the pointer at 3, requester 0 SHALL be searched first.
REQ-021 Operands SHALL be sampled only in LOAD; A_IN/B_IN changes at any other time SHALL NOT affect the result.
REQ-022 Deassertion of the granted REQ after LOAD SHALL NOT abort the operation; DONE and CMP are still issued.
REQ-023 A requester holding REQ through RESP SHALL be treated as a new request, subject to round-robin.
REQ-024 REQ bits that change while the FSM is not in IDLE SHALL be ignored until the FSM returns to IDLE.
REQ-025 There SHALL be no back-to-back grant: at least one IDLE cycle separates consecutive operations.
REQ-026 CMP SHALL be forced to 0 in every cycle where DONE=0.

Reset
REQ-027 Asserting RESET_N=0 SHALL immediately force FSM=IDLE, GNT=0, GNT_ID=0, DONE=0, CMP=0, pointer=3, and clear the operand and result registers.
REQ-028 Reset mid-operation SHALL discard the operation without a DONE pulse; after release, arbitration restarts at requester 0.
REQ-029 Reset release SHALL be treated as synchronous to CLK by the integrator; the first grant can occur at the first edge after release.

Configuration
REQ-030 Macro CMP_ARBITER_STATS_EN defined: the block SHALL add output MATCH_CNT [15:0], counting RESP cycles with CMP=1, saturating at 16'hFFFF, and cleared by reset.
REQ-031 Macro CMP_ARBITER_STATS_EN undefined: MATCH_CNT and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Single requester: REQ=4'b0001, A0=8'h5A, B0=8'h5A -> GNT=0001, DONE pulse 3 cycles after the grant edge with CMP=1.
REQ-033 Mismatch: REQ=4'b0100, A2=8'hFF, B2=8'hFE -> GNT_ID=2, DONE=1, CMP=0.
REQ-034 Round-robin: REQ=4'b1111 held after reset -> grant order 0,1,2,3,0; each grant separated by one IDLE cycle.
REQ-035 Operand change after LOAD: A1=B1=8'h3C at LOAD, then A1 changes to 8'h00 during EVAL -> CMP=1.
REQ-036 Reset in EVAL: RESET_N pulsed low -> no DONE, outputs 0, next REQ=4'b1000 is granted normally with pointer wrap.
REQ-037 With CMP_ARBITER_STATS_EN defined: 3 matching and 2 mismatching operations -> MATCH_CNT=3; preloaded near 16'hFFFF it saturates at 16'hFFFF.
